// File: rtl/fsub_pipe.sv
// rtl/fsub_pipe.sv - pipelined IEEE-754 single-precision subtractor y = x1 - x2
//
// Purpose : three-stage floating-point subtractor with round-to-nearest-even.
//           A pair sampled on an enabled edge is returned three enabled edges later.
// Ports   : clk        clock, all state on the rising edge
//           rstn       synchronous active-low reset (clears valid bits, y, ovf)
//           en         pipeline advance; low freezes every register
//           valid_in   x1/x2 carry a real operation
//           x1, x2     minuend / subtrahend, IEEE-754 single
//           valid_out  y/ovf hold the result of an accepted operation
//           y          x1 - x2, IEEE-754 single
//           ovf        finite operands produced +/-inf
// Config  : FSUB_DENORM_EN defined   -> full subnormal support, gradual underflow
//           FSUB_DENORM_EN undefined -> subnormal inputs read as signed zero,
//                                       subnormal results flush to signed zero
module fsub_pipe (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        valid_in,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        valid_out,
    output logic [31:0] y,
    output logic        ovf
);
    // operand capture
    logic        s0_v;
    logic [31:0] s0_x1, s0_x2;

    // S1: unpack, classify, swap
    logic [7:0]  e1, e2, ex1, ex2, ea_c, eb_c, ediff;
    logic [22:0] f1, f2;
    logic [23:0] m1, m2, ma_c, mb_c;
    logic        nan1, nan2, inf1, inf2, sgn1, sgn2, swap, spec_c;
    logic [31:0] spec_y_c;

    always_comb begin
        e1   = s0_x1[30:23];
        e2   = s0_x2[30:23];
        f1   = s0_x1[22:0];
        f2   = s0_x2[22:0];
        sgn1 = s0_x1[31];
        sgn2 = ~s0_x2[31];
        nan1 = (e1 == 8'hFF) && (f1 != 23'd0);
        nan2 = (e2 == 8'hFF) && (f2 != 23'd0);
        inf1 = (e1 == 8'hFF) && (f1 == 23'd0);
        inf2 = (e2 == 8'hFF) && (f2 == 23'd0);
        // subnormals share the scale of exponent 1
        ex1  = (e1 == 8'd0) ? 8'd1 : e1;
        ex2  = (e2 == 8'd0) ? 8'd1 : e2;
`ifdef FSUB_DENORM_EN
        m1   = {|e1, f1};
        m2   = {|e2, f2};
`else
        m1   = (e1 == 8'd0) ? 24'd0 : {1'b1, f1};
        m2   = (e2 == 8'd0) ? 24'd0 : {1'b1, f2};
`endif
        swap  = {ex2, m2} > {ex1, m1};
        ea_c  = swap ? ex2 : ex1;
        eb_c  = swap ? ex1 : ex2;
        ma_c  = swap ? m2 : m1;
        mb_c  = swap ? m1 : m2;
        ediff = ea_c - eb_c;

        spec_c = nan1 | nan2 | inf1 | inf2;
        if (nan1)
            spec_y_c = s0_x1 | 32'h0040_0000;
        else if (nan2)
            spec_y_c = s0_x2 | 32'h0040_0000;
        else if (inf1 && inf2 && (s0_x1[31] == s0_x2[31]))
            spec_y_c = 32'hFFC0_0000;
        else if (inf1)
            spec_y_c = s0_x1;
        else
            spec_y_c = {sgn2, s0_x2[30:0]};
    end

    logic        s1_v, s1_spec, s1_sign, s1_sub, s1_zs;
    logic [31:0] s1_spec_y;
    logic [7:0]  s1_ea;
    logic [23:0] s1_ma, s1_mb;
    logic [4:0]  s1_d;

    // S2: align B with guard/round/sticky, then add or subtract
    logic [55:0] b_sh;
    logic [26:0] a_fld, b_fld;
    logic [27:0] sum_c;

    assign b_sh  = {s1_mb, 32'd0} >> s1_d;
    assign b_fld = {b_sh[55:30], |b_sh[29:0]};
    assign a_fld = {s1_ma, 3'b000};
    assign sum_c = s1_sub ? ({1'b0, a_fld} - {1'b0, b_fld})
                          : ({1'b0, a_fld} + {1'b0, b_fld});

    logic        s2_v, s2_spec, s2_sign, s2_zs;
    logic [31:0] s2_spec_y;
    logic [7:0]  s2_ea;
    logic [27:0] s2_sum;

    // S3: normalize, round, pack
    logic [4:0]  lz;
    logic [8:0]  lim, sh_amt, e_res;
    logic [26:0] norm;
    logic        rnd, ovf_c;
    logic [7:0]  e_fld;
    logic [30:0] packed_c;
    logic [31:0] y_c;

    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++)
            if (s2_sum[i]) lz = 5'd26 - 5'(i);
        // never shift below exponent 1; what is left over is a subnormal
        lim    = {1'b0, s2_ea} - 9'd1;
        sh_amt = ({4'd0, lz} > lim) ? lim : {4'd0, lz};
        if (s2_sum[27]) begin
            norm  = {s2_sum[27:2], |s2_sum[1:0]};
            e_res = {1'b0, s2_ea} + 9'd1;
        end else begin
            norm  = s2_sum[26:0] << sh_amt;
            e_res = {1'b0, s2_ea} - sh_amt;
        end
        rnd   = norm[2] & (norm[3] | norm[1] | norm[0]);
        e_fld = norm[26] ? e_res[7:0] : 8'd0;
        // a mantissa carry ripples into the exponent field, renormalizing for free
        packed_c = {e_fld, norm[25:3]} + {30'd0, rnd};
        ovf_c    = 1'b0;
        if (s2_spec)
            y_c = s2_spec_y;
        else if (s2_sum == 28'd0)
            y_c = {s2_zs, 31'd0};
`ifndef FSUB_DENORM_EN
        else if (!norm[26])
            y_c = {s2_sign, 31'd0};
`endif
        else if ((e_res >= 9'd255) || (packed_c[30:23] == 8'hFF)) begin
            y_c   = {s2_sign, 8'hFF, 23'd0};
            ovf_c = 1'b1;
        end else
            y_c = {s2_sign, packed_c};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s0_v      <= 1'b0;
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            valid_out <= 1'b0;
            y         <= 32'd0;
            ovf       <= 1'b0;
        end else if (en) begin
            s0_v      <= valid_in;
            s0_x1     <= x1;
            s0_x2     <= x2;

            s1_v      <= s0_v;
            s1_spec   <= spec_c;
            s1_spec_y <= spec_y_c;
            s1_sign   <= swap ? sgn2 : sgn1;
            s1_sub    <= sgn1 ^ sgn2;
            // only two zeros of negative effective sign sum to -0
            s1_zs     <= sgn1 & sgn2;
            s1_ea     <= ea_c;
            s1_ma     <= ma_c;
            s1_mb     <= mb_c;
            s1_d      <= (ediff > 8'd31) ? 5'd31 : ediff[4:0];

            s2_v      <= s1_v;
            s2_spec   <= s1_spec;
            s2_spec_y <= s1_spec_y;
            s2_sign   <= s1_sign;
            s2_zs     <= s1_zs;
            s2_ea     <= s1_ea;
            s2_sum    <= sum_c;

            valid_out <= s2_v;
            y         <= y_c;
            ovf       <= ovf_c;
        end
    end
endmodule
